// File: rtl/sst_pkg.sv
// rtl/sst_pkg.sv - shared types and constants for the save-state sequencer
package sst_pkg;

  localparam int SST_ADDR_W = 8;
  localparam int SST_DATA_W = 8;
  // One bit wider than the address so a 256-slot walk ends cleanly.
  localparam int SLOT_CNT_W = SST_ADDR_W + 1;

  // Slot the mapper reserves for map_idx readback.
  localparam logic [SST_ADDR_W-1:0] MAP_IDX_SLOT = 8'd127;

  typedef enum logic [3:0] {
    IDLE,
    SETUP,
    FETCH,
    CAPTURE,
    ARM,
    WAIT_FALL,
    RELEASE,
    NEXT,
    DONE
  } sst_state_e;

endpackage

// File: rtl/m2_edge_sync.sv
// rtl/m2_edge_sync.sv - cpu.m2 synchronizer with falling-edge pulse
module m2_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic m2,
  output logic m2_level,
  output logic m2_fall
);

  logic sync1;
  logic sync2;
  logic prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= m2;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign m2_level = sync2;
  assign m2_fall  = prev & ~sync2;

endmodule

// File: rtl/sst_seq.sv
// rtl/sst_seq.sv - save-state sequencer driving the mapper sst register bus
module sst_seq
  import sst_pkg::*;
#(
  parameter int NUM_REGS   = 128,
  parameter int SETTLE     = 2,
  parameter int M2_TIMEOUT = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m2,
  input  logic                  start_save,
  input  logic                  start_load,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  sst_act,
  output logic                  sst_we_reg,
  output logic [SST_ADDR_W-1:0] sst_addr,
  output logic [SST_DATA_W-1:0] sst_dato,
  input  logic [SST_DATA_W-1:0] sst_di,
  output logic [SST_ADDR_W-1:0] buf_addr,
  output logic                  buf_we,
  output logic [SST_DATA_W-1:0] buf_wdata,
  input  logic [SST_DATA_W-1:0] buf_rdata
);

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int TW = (M2_TIMEOUT > 1) ? $clog2(M2_TIMEOUT) : 1;
  localparam logic [SLOT_CNT_W-1:0] LAST_SLOT   = SLOT_CNT_W'(NUM_REGS - 1);
  localparam logic [SW-1:0]         SETTLE_LAST = SW'(SETTLE - 1);
  localparam logic [TW-1:0]         TMO_LAST    = TW'(M2_TIMEOUT - 1);

  sst_state_e            state;
  sst_state_e            state_next;
  logic                  m2_timeout;
  logic                  load_mode;
  logic [SLOT_CNT_W-1:0] slot;
  logic [SW-1:0]         settle_cnt;
  logic [TW-1:0]         tmo_cnt;
  logic                  m2_seen_high;
  logic                  m2_level;
  logic                  m2_fall;

  m2_edge_sync u_m2_sync (
    .clk      (clk),
    .rst      (rst),
    .m2       (m2),
    .m2_level (m2_level),
    .m2_fall  (m2_fall)
  );

  always_comb begin
    state_next = state;
    m2_timeout = 1'b0;
    case (state)
      IDLE:      if (start_save || start_load) state_next = SETUP;
      SETUP: begin
        if (load_mode)                      state_next = FETCH;
        else if (settle_cnt == SETTLE_LAST) state_next = CAPTURE;
      end
      FETCH:     state_next = ARM;
      CAPTURE:   state_next = NEXT;
      ARM:       state_next = WAIT_FALL;
      WAIT_FALL: begin
        if (m2_fall && m2_seen_high) begin
          state_next = RELEASE;
        end else if (tmo_cnt == TMO_LAST) begin
          state_next = IDLE;
          m2_timeout = 1'b1;
        end
      end
      RELEASE:   state_next = NEXT;
      NEXT:      state_next = (slot == LAST_SLOT) ? DONE : SETUP;
      DONE:      state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Outputs are registered decodes of the next state so strobes are glitch-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      sst_act    <= 1'b0;
      sst_we_reg <= 1'b0;
      buf_we     <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_next;
      busy       <= (state_next != IDLE) && (state_next != DONE);
      sst_act    <= (state_next != IDLE) && (state_next != DONE);
      sst_we_reg <= (state_next == WAIT_FALL);
      buf_we     <= (state_next == CAPTURE);
      done       <= (state_next == DONE);
      err        <= m2_timeout;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      load_mode    <= 1'b0;
      slot         <= '0;
      settle_cnt   <= '0;
      tmo_cnt      <= '0;
      m2_seen_high <= 1'b0;
      sst_dato     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_save || start_load) begin
            slot       <= '0;
            load_mode  <= ~start_save;
            settle_cnt <= '0;
          end
        end
        SETUP: settle_cnt <= settle_cnt + 1'b1;
        ARM: begin
          sst_dato     <= buf_rdata;
          tmo_cnt      <= '0;
          m2_seen_high <= 1'b0;
        end
        WAIT_FALL: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          // Only a fall after m2 was sampled high with the strobe already up
          // guarantees the mapper saw the write at its own m2 edge.
          if ((tmo_cnt != '0) && m2_level) m2_seen_high <= 1'b1;
        end
        NEXT: begin
          settle_cnt <= '0;
          if (slot != LAST_SLOT) slot <= slot + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign sst_addr  = slot[SST_ADDR_W-1:0];
  assign buf_addr  = slot[SST_ADDR_W-1:0];
  assign buf_wdata = buf_we ? sst_di : '0;

endmodule

// File: tb/tb_sst_seq.sv
// tb/tb_sst_seq.sv - directed self-checking bench for sst_seq
module tb_sst_seq;

  logic       clk, rst, m2;
  logic       start_save, start_load;
  logic       busy, done, err, sst_act, sst_we_reg, buf_we;
  logic [7:0] sst_addr, sst_dato, sst_di, buf_addr, buf_wdata, buf_rdata;

  logic       start_save2, start_load2;
  logic       busy2, done2, err2, sst_act2, sst_we_reg2, buf_we2;
  logic [7:0] sst_addr2, sst_dato2, sst_di2, buf_addr2, buf_wdata2, buf_rdata2;

  int n_checks = 0;
  int n_pass   = 0;
  int cur_gen  = 1;

  logic [7:0] bmem    [256];
  int         bgen    [256];
  logic [7:0] map_val [256];
  int         map_gen [256];

  int n_bufwe = 0, n_done = 0, n_err = 0, n_we_cyc = 0, n_commit = 0, n_early = 0;
  int commit_at_rise = 0;
  logic we_prev = 1'b0;
  int n_bufwe2 = 0, n_done2 = 0, n_err2 = 0, n_we2 = 0, n_wrap2 = 0, n_bad2 = 0;
  logic [7:0] last_addr2 = 8'h00;

  bit stop_en = 1'b0;
  bit halted  = 1'b0;

  sst_seq #(.NUM_REGS(16), .SETTLE(2), .M2_TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .m2(m2), .start_save(start_save), .start_load(start_load),
    .busy(busy), .done(done), .err(err), .sst_act(sst_act), .sst_we_reg(sst_we_reg),
    .sst_addr(sst_addr), .sst_dato(sst_dato), .sst_di(sst_di), .buf_addr(buf_addr),
    .buf_we(buf_we), .buf_wdata(buf_wdata), .buf_rdata(buf_rdata)
  );

  sst_seq #(.NUM_REGS(256), .SETTLE(2), .M2_TIMEOUT(64)) dut256 (
    .clk(clk), .rst(rst), .m2(m2), .start_save(start_save2), .start_load(start_load2),
    .busy(busy2), .done(done2), .err(err2), .sst_act(sst_act2), .sst_we_reg(sst_we_reg2),
    .sst_addr(sst_addr2), .sst_dato(sst_dato2), .sst_di(sst_di2), .buf_addr(buf_addr2),
    .buf_we(buf_we2), .buf_wdata(buf_wdata2), .buf_rdata(buf_rdata2)
  );

  // Mapper readback model and an always-zero buffer for the wide instance.
  assign sst_di     = sst_addr ^ 8'hA5;
  assign sst_di2    = sst_addr2 ^ 8'hA5;
  assign buf_rdata2 = 8'h00;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // m2: 12-clk period, edges offset from clk; optionally parked low after slot 4 commits.
  initial begin
    m2 = 1'b0;
    #3;
    forever begin
      if (stop_en && halted) begin
        m2 = 1'b0;
        #10;
      end else begin
        m2 = 1'b1;
        #60;
        m2 = 1'b0;
        if (stop_en && sst_we_reg && sst_addr == 8'd4) halted = 1'b1;
        #60;
      end
      if (!stop_en) halted = 1'b0;
    end
  end

  // Buffer model: unwritten-this-generation slots read back as addr*3.
  always @(posedge clk) begin
    buf_rdata <= (bgen[buf_addr] == cur_gen) ? bmem[buf_addr] : 8'(buf_addr * 3);
    if (buf_we) begin
      bmem[buf_addr] <= buf_wdata;
      bgen[buf_addr] <= cur_gen;
    end
  end

  // Mapper commits on the real m2 fall.
  always @(negedge m2) begin
    if (sst_we_reg) begin
      map_val[sst_addr] = sst_dato;
      map_gen[sst_addr] = cur_gen;
      n_commit++;
    end
  end

  always @(negedge clk) begin
    if (buf_we) n_bufwe++;
    if (done) n_done++;
    if (err) n_err++;
    if (sst_we_reg) n_we_cyc++;
    if (sst_we_reg && !we_prev) commit_at_rise = n_commit;
    if (!sst_we_reg && we_prev && n_commit == commit_at_rise) n_early++;
    we_prev = sst_we_reg;
    if (buf_we2) begin
      n_bufwe2++;
      if (n_bufwe2 > 1 && buf_addr2 <= last_addr2) n_wrap2++;
      if (buf_wdata2 !== (buf_addr2 ^ 8'hA5)) n_bad2++;
      last_addr2 = buf_addr2;
    end
    if (done2) n_done2++;
    if (err2) n_err2++;
    if (sst_we_reg2) n_we2++;
  end

  task automatic pulse_start(input bit s, input bit l);
    start_save = s;
    start_load = l;
    @(negedge clk);
    start_save = 1'b0;
    start_load = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start_save = 1'b0; start_load = 1'b0; start_save2 = 1'b0; start_load2 = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, done, err, sst_act, sst_we_reg, buf_we} !== 6'b0)
      $display("FAIL reset_ctrl: got %b want 000000", {busy, done, err, sst_act, sst_we_reg, buf_we});
    else n_pass++;
    n_checks++;
    if ({sst_addr, sst_dato, buf_addr, buf_wdata} !== 32'h0)
      $display("FAIL reset_data: got %h want 00000000", {sst_addr, sst_dato, buf_addr, buf_wdata});
    else n_pass++;
    n_checks++;
    if ({busy2, sst_act2, sst_we_reg2, buf_we2} !== 4'b0)
      $display("FAIL reset_dut256: got %b want 0000", {busy2, sst_act2, sst_we_reg2, buf_we2});
    else n_pass++;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) $display("FAIL idle_after_reset: busy got %b want 0", busy);
    else n_pass++;
  endtask

  task automatic test_save();
    int cyc, busy_bad, bw0, d0, we0, bad;
    cur_gen++;
    bw0 = n_bufwe; d0 = n_done; we0 = n_we_cyc; busy_bad = 0; bad = 0;
    pulse_start(1'b1, 1'b0);
    cyc = 1;
    while (!done && cyc < 1000) begin
      if (!busy || !sst_act) busy_bad++;
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (cyc !== 65) $display("FAIL save_latency: got %0d cycles want 65", cyc);
    else n_pass++;
    n_checks++;
    if ({busy, sst_act} !== 2'b00) $display("FAIL save_done_idle: busy/act got %b want 00", {busy, sst_act});
    else n_pass++;
    n_checks++;
    if (busy_bad !== 0) $display("FAIL save_busy_held: drops got %0d want 0", busy_bad);
    else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++;
    if (n_bufwe - bw0 !== 16) $display("FAIL save_bufwe_count: got %0d want 16", n_bufwe - bw0);
    else n_pass++;
    n_checks++;
    if (n_done - d0 !== 1) $display("FAIL save_done_count: got %0d want 1", n_done - d0);
    else n_pass++;
    n_checks++;
    if (n_we_cyc - we0 !== 0) $display("FAIL save_no_reg_write: got %0d want 0", n_we_cyc - we0);
    else n_pass++;
    for (int i = 0; i < 16; i++)
      if (bgen[i] != cur_gen || bmem[i] !== 8'(i ^ 8'hA5)) bad++;
    n_checks++;
    if (bad !== 0) $display("FAIL save_buffer_data: bad slots got %0d want 0", bad);
    else n_pass++;
    n_checks++;
    if (bgen[16] == cur_gen) $display("FAIL save_no_overrun: slot16 written got 1 want 0");
    else n_pass++;
  endtask

  task automatic test_load();
    int cyc, d0, e0, early0, bad;
    cur_gen++;
    d0 = n_done; e0 = n_err; early0 = n_early; bad = 0;
    pulse_start(1'b0, 1'b1);
    cyc = 1;
    while (!done && cyc < 3000) begin @(negedge clk); cyc++; end
    n_checks++;
    if (cyc >= 3000) $display("FAIL load_done_seen: timed out got %0d cycles want <3000", cyc);
    else n_pass++;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 16; i++)
      if (map_gen[i] != cur_gen || map_val[i] !== 8'(i * 3)) bad++;
    n_checks++;
    if (bad !== 0) $display("FAIL load_mapper_regs: bad slots got %0d want 0", bad);
    else n_pass++;
    n_checks++;
    if (n_early - early0 !== 0) $display("FAIL load_we_before_fall: got %0d want 0", n_early - early0);
    else n_pass++;
    n_checks++;
    if (n_done - d0 !== 1 || n_err - e0 !== 0)
      $display("FAIL load_done_err: done got %0d want 1, err got %0d want 0", n_done - d0, n_err - e0);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int cyc, cnt5, d0, bad;
    cur_gen++;
    stop_en = 1'b1;
    d0 = n_done; cnt5 = 0; bad = 0;
    pulse_start(1'b0, 1'b1);
    cyc = 1;
    while (!err && cyc < 3000) begin
      if (sst_we_reg && sst_addr == 8'd5) cnt5++;
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (cyc >= 3000) $display("FAIL tmo_err_seen: timed out got %0d cycles want <3000", cyc);
    else n_pass++;
    n_checks++;
    if ({sst_act, busy, sst_we_reg} !== 3'b000)
      $display("FAIL tmo_bus_released: act/busy/we got %b want 000", {sst_act, busy, sst_we_reg});
    else n_pass++;
    n_checks++;
    if (cnt5 !== 64) $display("FAIL tmo_wait_cycles: got %0d want 64", cnt5);
    else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++;
    if (n_done - d0 !== 0) $display("FAIL tmo_no_done: got %0d want 0", n_done - d0);
    else n_pass++;
    for (int i = 0; i < 5; i++)
      if (map_gen[i] != cur_gen || map_val[i] !== 8'(i * 3)) bad++;
    n_checks++;
    if (bad !== 0) $display("FAIL tmo_slots_written: bad got %0d want 0", bad);
    else n_pass++;
    bad = 0;
    for (int i = 5; i < 16; i++)
      if (map_gen[i] == cur_gen) bad++;
    n_checks++;
    if (bad !== 0) $display("FAIL tmo_slots_untouched: written got %0d want 0", bad);
    else n_pass++;
    stop_en = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_both_starts();
    int cyc, bw0, d0, we0;
    cur_gen++;
    bw0 = n_bufwe; d0 = n_done; we0 = n_we_cyc;
    pulse_start(1'b1, 1'b1);
    repeat (5) @(negedge clk);
    pulse_start(1'b0, 1'b1);
    cyc = 7;
    while (!done && cyc < 1000) begin @(negedge clk); cyc++; end
    repeat (5) @(negedge clk);
    n_checks++;
    if (n_bufwe - bw0 !== 16) $display("FAIL both_save_wins: bufwe got %0d want 16", n_bufwe - bw0);
    else n_pass++;
    n_checks++;
    if (n_we_cyc - we0 !== 0) $display("FAIL both_no_load: we cycles got %0d want 0", n_we_cyc - we0);
    else n_pass++;
    n_checks++;
    if (n_done - d0 !== 1 || busy !== 1'b0)
      $display("FAIL busy_start_ignored: done got %0d want 1, busy got %b want 0", n_done - d0, busy);
    else n_pass++;
  endtask

  task automatic test_rst_mid_load();
    int cyc, d0, e0, bw0, bad;
    cur_gen++;
    pulse_start(1'b0, 1'b1);
    cyc = 1;
    while (!(sst_we_reg && sst_addr == 8'd7) && cyc < 3000) begin @(negedge clk); cyc++; end
    n_checks++;
    if (cyc >= 3000) $display("FAIL rst_reach_slot7: timed out got %0d cycles want <3000", cyc);
    else n_pass++;
    d0 = n_done; e0 = n_err;
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({busy, sst_act, sst_we_reg} !== 3'b000)
      $display("FAIL rst_mid_load: busy/act/we got %b want 000", {busy, sst_act, sst_we_reg});
    else n_pass++;
    rst = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++;
    if (n_done - d0 !== 0 || n_err - e0 !== 0)
      $display("FAIL rst_no_pulse: done got %0d err got %0d want 0 0", n_done - d0, n_err - e0);
    else n_pass++;
    cur_gen++;
    bw0 = n_bufwe; bad = 0;
    pulse_start(1'b1, 1'b0);
    cyc = 1;
    while (!done && cyc < 1000) begin @(negedge clk); cyc++; end
    n_checks++;
    if (cyc !== 65) $display("FAIL rst_resave_latency: got %0d want 65", cyc);
    else n_pass++;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 16; i++)
      if (bgen[i] != cur_gen || bmem[i] !== 8'(i ^ 8'hA5)) bad++;
    n_checks++;
    if (bad !== 0 || n_bufwe - bw0 !== 16)
      $display("FAIL rst_resave_data: bad got %0d want 0, writes got %0d want 16", bad, n_bufwe - bw0);
    else n_pass++;
  endtask

  task automatic test_save_256();
    int cyc;
    start_save2 = 1'b1;
    @(negedge clk);
    start_save2 = 1'b0;
    cyc = 1;
    while (!done2 && cyc < 3000) begin @(negedge clk); cyc++; end
    n_checks++;
    if (cyc !== 1025) $display("FAIL save256_latency: got %0d want 1025", cyc);
    else n_pass++;
    n_checks++;
    if ({busy2, sst_act2} !== 2'b00) $display("FAIL save256_idle: busy/act got %b want 00", {busy2, sst_act2});
    else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++;
    if (n_bufwe2 !== 256) $display("FAIL save256_count: got %0d want 256", n_bufwe2);
    else n_pass++;
    n_checks++;
    if (last_addr2 !== 8'd255 || n_wrap2 !== 0)
      $display("FAIL save256_last: addr got %0d want 255, wraps got %0d want 0", last_addr2, n_wrap2);
    else n_pass++;
    n_checks++;
    if (n_bad2 !== 0 || n_done2 !== 1 || n_err2 !== 0 || n_we2 !== 0 || sst_dato2 !== 8'h00)
      $display("FAIL save256_misc: bad %0d done %0d err %0d we %0d dato %0d want 0 1 0 0 0",
               n_bad2, n_done2, n_err2, n_we2, sst_dato2);
    else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    start_save = 1'b0; start_load = 1'b0; start_save2 = 1'b0; start_load2 = 1'b0;
    test_reset();
    test_save();
    test_load();
    test_timeout();
    test_both_starts();
    test_rst_mid_load();
    test_save_256();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
